// File: rtl/ext_razor_multi_if.sv
// ext_razor_multi_if
//   Operand and result handshake bundle for the extrinsic (be1) unit.
//   The master side is the upstream alpha/beta source plus the downstream
//   consumer. The slave side is the extrinsic unit itself.
//   Signals:
//     in_valid / in_ready    operand-set handshake
//     alpha, beta            CH*7*M bits. Element k (1..7) of channel c sits at
//                            [(c*7 + k-1)*M +: M], signed two's complement
//     ba2                    CH*N bits. Channel c sits at [c*N +: N], signed
//     out_valid / out_ready  result handshake
//     be1                    CH*M bits. Channel c sits at [c*M +: M], signed
interface ext_razor_multi_if #(
    parameter int N  = 5,
    parameter int M  = 6,
    parameter int CH = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [CH*7*M-1:0] alpha;
    logic [CH*7*M-1:0] beta;
    logic [CH*N-1:0]   ba2;
    logic              out_valid;
    logic              out_ready;
    logic [CH*M-1:0]   be1;

    modport master (
        output in_valid, alpha, beta, ba2, out_ready,
        input  in_ready, out_valid, be1
    );

    modport slave (
        input  in_valid, alpha, beta, ba2, out_ready,
        output in_ready, out_valid, be1
    );
endinterface

// File: rtl/ext_razor_multi.sv
// ext_razor_multi
//   Computes the CH-channel max-log extrinsic value be1 = sat_M(B - A) from
//   alpha/beta/ba2. The top RB bits of each channel's result are re-sampled
//   by a shadow capture. When a mismatch is found, the result is replayed
//   from the shadow copy before it is presented.
// Ports:
//   Clock          rising-edge clock
//   nReset         synchronous active-low reset
//   bus            ext_razor_multi_if.slave: operands in, be1 out, valid/ready on both sides
//   Error_prev_a   upstream alpha unit error; blocks acceptance
//   Error_prev_b   upstream beta unit error; blocks acceptance
//   tst_flip       per-channel test inversion of be1 bit M-1, main capture only
//   Error_current  per-channel mismatch of the last checked result, held until next accept
//   err_count      saturating count of corrected channel events
//   clr_count      synchronous clear of err_count; takes priority over an increment
module ext_razor_multi #(
    parameter int N  = 5,
    parameter int M  = 6,
    parameter int CH = 4,
    parameter int RB = 1,
    parameter int CW = 8
) (
    input  logic             Clock,
    input  logic             nReset,
    ext_razor_multi_if.slave bus,
    input  logic             Error_prev_a,
    input  logic             Error_prev_b,
    input  logic [CH-1:0]    tst_flip,
    output logic [CH-1:0]    Error_current,
    output logic [CW-1:0]    err_count,
    input  logic             clr_count
);
    localparam int SW  = M + 3;          // width that holds B-A exactly
    localparam int PW  = $clog2(CH + 1); // width of a per-op mismatch count
    localparam int OPW = 7 * M;          // one channel's alpha (or beta) vector

    localparam logic signed [SW-1:0] ZERO    = '0;
    localparam logic signed [SW-1:0] SAT_HI  = SW'((2 ** (M - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_LO  = ~SAT_HI;
    localparam logic [CW+PW-1:0]     CNT_MAX = {{PW{1'b0}}, {CW{1'b1}}};

    typedef enum logic [2:0] {S_IDLE, S_EVAL, S_CHECK, S_CORRECT, S_OUT} state_t;

    function automatic logic signed [SW-1:0] smax(input logic signed [SW-1:0] x,
                                                  input logic signed [SW-1:0] y);
        return (x > y) ? x : y;
    endfunction

    // One channel of the max-log kernel. Every term is sign-extended to SW
    // bits up front, so the sums and the difference can never wrap.
    function automatic logic [M-1:0] extrinsic(input logic [OPW-1:0] a_v,
                                               input logic [OPW-1:0] b_v,
                                               input logic [N-1:0]   ba_v);
        logic signed [SW-1:0] a [1:7];
        logic signed [SW-1:0] b [1:7];
        logic signed [SW-1:0] ba, p, q, r, s, d;
        logic [M-1:0]         y;
        for (int k = 1; k <= 7; k++) begin
            a[k] = SW'($signed(a_v[(k-1)*M +: M]));
            b[k] = SW'($signed(b_v[(k-1)*M +: M]));
        end
        ba = SW'($signed(ba_v));
        p  = smax(smax(ZERO, a[1] + b[4]), smax(a[6] + b[7], a[7] + b[3]));
        q  = smax(smax(a[2] + b[5], a[3] + b[1]), smax(a[4] + b[2], a[5] + b[6])) + ba;
        r  = smax(smax(a[2] + b[1], a[3] + b[5]), smax(a[4] + b[6], a[5] + b[2]));
        s  = smax(smax(b[4], a[1]), smax(a[6] + b[3], a[7] + b[7])) + ba;
        d  = smax(r, s) - smax(p, q);
        if (d > SAT_HI)      y = SAT_HI[M-1:0];
        else if (d < SAT_LO) y = SAT_LO[M-1:0];
        else                 y = d[M-1:0];
        return y;
    endfunction

    state_t            state, state_nxt;
    logic [CH*OPW-1:0] alpha_q, beta_q;
    logic [CH*N-1:0]   ba2_q;
    logic [M-1:0]      res      [CH];
    logic [M-1:0]      main_q   [CH];
    logic [M-1:0]      shadow_q [CH];
    logic [CH-1:0]     mis;
    logic [PW-1:0]     mis_cnt;
    logic [CW+PW-1:0]  cnt_sum;
    logic              accept;

    // The held operands feed the kernel continuously. The main and shadow
    // captures happen on different edges, which is what lets the shadow
    // capture catch an upset in the main capture.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            res[c] = extrinsic(alpha_q[c*OPW +: OPW], beta_q[c*OPW +: OPW], ba2_q[c*N +: N]);
            mis[c] = main_q[c][M-1 -: RB] != res[c][M-1 -: RB];
        end
    end

    always_comb begin
        mis_cnt = '0;
        for (int c = 0; c < CH; c++) mis_cnt = mis_cnt + PW'(mis[c]);
        cnt_sum = {{PW{1'b0}}, err_count} + {{CW{1'b0}}, mis_cnt};
    end

    // A result leaving OUT frees the unit in the same cycle.
    // This gives back-to-back operation at one op every three cycles.
    assign bus.in_ready  = (state == S_IDLE) || ((state == S_OUT) && bus.out_ready);
    assign bus.out_valid = (state == S_OUT);
    assign accept        = bus.in_valid && bus.in_ready && !(Error_prev_a || Error_prev_b);

    always_comb begin
        bus.be1 = '0;
        for (int c = 0; c < CH; c++) bus.be1[c*M +: M] = main_q[c];
    end

    // NOTE: state_nxt gets its default before the case, so every path assigns it and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (accept) state_nxt = S_EVAL;
            S_EVAL:    state_nxt = S_CHECK;
            S_CHECK:   state_nxt = (|mis) ? S_CORRECT : S_OUT;
            S_CORRECT: state_nxt = S_OUT;
            S_OUT:     if (bus.out_ready) state_nxt = accept ? S_EVAL : S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (!nReset) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // NOTE: operand and shadow registers have no reset. Each one is written before any state that reads it.
    always_ff @(posedge Clock) begin
        if (accept) begin
            alpha_q <= bus.alpha;
            beta_q  <= bus.beta;
            ba2_q   <= bus.ba2;
        end
        if (state == S_CHECK) shadow_q <= res;
    end

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            main_q        <= '{default: '0};
            Error_current <= '0;
            err_count     <= '0;
        end else begin
            case (state)
                S_EVAL: begin
                    for (int c = 0; c < CH; c++)
                        main_q[c] <= res[c] ^ {tst_flip[c], {(M-1){1'b0}}};
                end
                S_CORRECT: main_q <= shadow_q;
                default: ;
            endcase

            if (accept)                          Error_current <= '0;
            else if ((state == S_CHECK) && |mis) Error_current <= mis;

            if (clr_count)
                err_count <= '0;
            else if ((state == S_CHECK) && |mis)
                err_count <= (cnt_sum > CNT_MAX) ? CNT_MAX[CW-1:0] : cnt_sum[CW-1:0];
        end
    end
endmodule

// File: tb/tb_ext_razor_multi.sv
// tb_ext_razor_multi
//   Drives ext_razor_multi with directed and randomized operand sets.
//   Every cycle, the DUT outputs are compared against a transaction-level
//   model. The model computes be1 with plain integer max-log arithmetic and
//   tracks timing as an age counter measured from each accept.
`timescale 1ns/1ps
module tb_ext_razor_multi;
    localparam int N       = 5;
    localparam int M       = 6;
    localparam int CH      = 4;
    localparam int RB      = 1;
    localparam int CW      = 8;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam int BUDGET  = 12;

    typedef int vec7_t [1:7];

    logic          Clock = 1'b0;
    logic          nReset;
    logic          Error_prev_a, Error_prev_b, clr_count;
    logic [CH-1:0] tst_flip;
    logic [CH-1:0] Error_current;
    logic [CW-1:0] err_count;

    ext_razor_multi_if #(.N(N), .M(M), .CH(CH)) bus ();

    ext_razor_multi #(.N(N), .M(M), .CH(CH), .RB(RB), .CW(CW)) dut (
        .Clock        (Clock),
        .nReset       (nReset),
        .bus          (bus),
        .Error_prev_a (Error_prev_a),
        .Error_prev_b (Error_prev_b),
        .tst_flip     (tst_flip),
        .Error_current(Error_current),
        .err_count    (err_count),
        .clr_count    (clr_count)
    );

    always #5 Clock = ~Clock;

    int    n_tests = 0;
    int    n_fail  = 0;
    vec7_t cur_a [CH];
    vec7_t cur_b [CH];
    int    cur_ba[CH];

    // Model state. m_age counts edges since accept (-1 = no op in flight).
    // m_ov means a result is being presented.
    int            m_age  = -1;
    bit            m_ov   = 1'b0;
    bit            m_live = 1'b0;
    logic [CH-1:0] m_flip = '0;
    logic [CH-1:0] m_err  = '0;
    int            m_cnt  = 0;
    int            m_res [CH];

    function automatic int max2(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    function automatic int max4(input int w, input int x, input int y, input int z);
        return max2(max2(w, x), max2(y, z));
    endfunction

    function automatic int be1_ref(input vec7_t a, input vec7_t b, input int ba);
        int p, q, r, s, d;
        p = max4(0, a[1] + b[4], a[6] + b[7], a[7] + b[3]);
        q = max4(a[2] + b[5], a[3] + b[1], a[4] + b[2], a[5] + b[6]) + ba;
        r = max4(a[2] + b[1], a[3] + b[5], a[4] + b[6], a[5] + b[2]);
        s = max4(b[4], a[1], a[6] + b[3], a[7] + b[7]) + ba;
        d = max2(r, s) - max2(p, q);
        if (d > (1 << (M - 1)) - 1) d = (1 << (M - 1)) - 1;
        if (d < -(1 << (M - 1)))    d = -(1 << (M - 1));
        return d;
    endfunction

    function automatic logic [CH*M-1:0] pack_be1(input int v [CH]);
        logic [CH*M-1:0] r;
        r = '0;
        for (int c = 0; c < CH; c++) r[c*M +: M] = v[c][M-1:0];
        return r;
    endfunction

    function automatic bit model_in_ready();
        return ((m_age < 0) && !m_ov) || (m_ov && bus.out_ready);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_ops();
        for (int c = 0; c < CH; c++) begin
            for (int k = 1; k <= 7; k++) begin
                bus.alpha[(c*7 + k-1)*M +: M] = cur_a[c][k][M-1:0];
                bus.beta [(c*7 + k-1)*M +: M] = cur_b[c][k][M-1:0];
            end
            bus.ba2[c*N +: N] = cur_ba[c][N-1:0];
        end
    endtask

    task automatic zero_ops();
        for (int c = 0; c < CH; c++) begin
            for (int k = 1; k <= 7; k++) begin
                cur_a[c][k] = 0;
                cur_b[c][k] = 0;
            end
            cur_ba[c] = 0;
        end
    endtask

    task automatic rand_ops();
        for (int c = 0; c < CH; c++) begin
            for (int k = 1; k <= 7; k++) begin
                cur_a[c][k] = int'($urandom_range(0, 63)) - 32;
                cur_b[c][k] = int'($urandom_range(0, 63)) - 32;
            end
            cur_ba[c] = int'($urandom_range(0, 31)) - 16;
        end
        drive_ops();
    endtask

    // Advance the model across one rising edge, using the inputs held at that edge.
    task automatic model_step();
        bit acc;
        int inc;
        int age0;
        bit ov0;
        if (!nReset) begin
            m_age  = -1;
            m_ov   = 1'b0;
            m_err  = '0;
            m_cnt  = 0;
            m_flip = '0;
            m_live = 1'b1;
            return;
        end
        acc  = bus.in_valid && model_in_ready() && !(Error_prev_a || Error_prev_b);
        inc  = 0;
        age0 = m_age;
        ov0  = m_ov;
        case (age0)
            0: begin
                m_flip = tst_flip;
                m_age  = 1;
            end
            1: begin
                if (m_flip != '0) begin
                    m_err = m_flip;
                    inc   = $countones(m_flip);
                    m_age = 2;
                end else begin
                    m_age = -1;
                    m_ov  = 1'b1;
                end
            end
            2: begin
                m_age = -1;
                m_ov  = 1'b1;
            end
            default: if (ov0 && bus.out_ready) m_ov = 1'b0;
        endcase
        if (acc) begin
            for (int c = 0; c < CH; c++) m_res[c] = be1_ref(cur_a[c], cur_b[c], cur_ba[c]);
            m_err = '0;
            m_age = 0;
        end
        if (clr_count) m_cnt = 0;
        else           m_cnt = (m_cnt + inc > CNT_MAX) ? CNT_MAX : m_cnt + inc;
    endtask

    // One clock cycle: check in_ready against the inputs just driven, cross
    // the rising edge, then compare the registered outputs on the falling edge.
    task automatic tick();
        #1;
        if (m_live) check("in_ready", 64'(bus.in_ready), 64'(model_in_ready()));
        @(posedge Clock);
        model_step();
        @(negedge Clock);
        if (m_live) begin
            check("out_valid", 64'(bus.out_valid), 64'(m_ov));
            check("Error_current", 64'(Error_current), 64'(m_err));
            check("err_count", 64'(err_count), 64'(m_cnt));
            if (m_ov) check("be1", 64'(bus.be1), 64'(pack_be1(m_res)));
        end
    endtask

    // Latency counts the accept cycle as 1.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < BUDGET) begin
            tick();
            lat++;
        end
        if (!bus.out_valid) check("out_valid_timeout", 64'(bus.out_valid), 64'd1);
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic load_clean_case();
        zero_ops();
        cur_a[0][2] = 5;
        cur_b[0][1] = 4;
        drive_ops();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            lat;
        bit            seen;
        logic [CH*M-1:0] exp_hold;
        int            hold_res [CH];

        // Reset while every input is active and nonzero.
        nReset        = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        Error_prev_a  = 1'b1;
        Error_prev_b  = 1'b1;
        clr_count     = 1'b1;
        tst_flip      = '1;
        for (int c = 0; c < CH; c++) begin
            for (int k = 1; k <= 7; k++) begin
                cur_a[c][k] = k;
                cur_b[c][k] = -k;
            end
            cur_ba[c] = 3;
        end
        drive_ops();
        tick();
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_be1", 64'(bus.be1), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_err_cur", 64'(Error_current), 64'd0);

        // Clean result: channel 0 gives 9 - 5 = 4.
        nReset        = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        Error_prev_a  = 1'b0;
        Error_prev_b  = 1'b0;
        clr_count     = 1'b0;
        tst_flip      = '0;
        load_clean_case();
        check("ref_clean", 64'(be1_ref(cur_a[0], cur_b[0], cur_ba[0])), 64'(4));
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        wait_out(lat);
        check("lat_clean", 64'(lat), 64'd3);
        check("be1_clean", 64'(bus.be1), 64'd4);
        check("err_clean", 64'(Error_current), 64'd0);
        consume();

        // Saturation. Channel 1 gives 62 and clamps to 31.
        // Channel 2 gives 15 - 62 and clamps to -32.
        zero_ops();
        cur_a[1][2] = 31;
        cur_b[1][1] = 31;
        cur_a[1][3] = -32;
        cur_b[1][5] = -32;
        cur_a[2][7] = 31;
        cur_b[2][3] = 31;
        cur_ba[2]   = -16;
        drive_ops();
        check("ref_sat_pos", 64'(be1_ref(cur_a[1], cur_b[1], cur_ba[1])), 64'(31));
        check("ref_sat_neg", 64'(be1_ref(cur_a[2], cur_b[2], cur_ba[2])), 64'(-32));
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        wait_out(lat);
        check("be1_sat", 64'(bus.be1), 64'({6'd0, 6'h20, 6'h1F, 6'd0}));
        consume();

        // Replay. Channels 0 and 2 have their MSB flipped, then are corrected.
        load_clean_case();
        tst_flip     = 4'b0101;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        wait_out(lat);
        tst_flip = '0;
        check("lat_replay", 64'(lat), 64'd4);
        check("err_cur_replay", 64'(Error_current), 64'h5);
        check("err_count_replay", 64'(err_count), 64'd2);
        check("be1_replay", 64'(bus.be1), 64'd4);
        consume();
        check("err_cur_sticky", 64'(Error_current), 64'h5);

        // An upstream error blocks acceptance. Backpressure holds the result.
        rand_ops();
        Error_prev_a = 1'b1;
        bus.in_valid = 1'b1;
        repeat (3) tick();
        check("hold_no_accept", 64'(bus.out_valid), 64'd0);
        Error_prev_a = 1'b0;
        for (int c = 0; c < CH; c++) hold_res[c] = be1_ref(cur_a[c], cur_b[c], cur_ba[c]);
        exp_hold = pack_be1(hold_res);
        tick();
        rand_ops();
        wait_out(lat);
        repeat (5) begin
            tick();
            check("bp_be1_stable", 64'(bus.be1), 64'(exp_hold));
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check("b2b_out_dropped", 64'(bus.out_valid), 64'd0);
        wait_out(lat);
        check("lat_b2b", 64'(lat), 64'd3);
        consume();

        // Randomized traffic.
        repeat (600) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            Error_prev_a  = ($urandom_range(0, 7) == 0);
            Error_prev_b  = ($urandom_range(0, 7) == 0);
            clr_count     = ($urandom_range(0, 31) == 0);
            tst_flip      = ($urandom_range(0, 3) == 0) ? CH'($urandom_range(0, 15)) : '0;
            rand_ops();
            tick();
        end

        // Counter saturation, then a clear.
        Error_prev_a  = 1'b0;
        Error_prev_b  = 1'b0;
        clr_count     = 1'b0;
        tst_flip      = '1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        repeat (300) begin
            rand_ops();
            tick();
        end
        check("cnt_saturated", 64'(err_count), 64'(CNT_MAX));
        tst_flip     = '0;
        bus.in_valid = 1'b0;
        clr_count    = 1'b1;
        tick();
        clr_count = 1'b0;
        check("cnt_cleared", 64'(err_count), 64'd0);

        // Reset in EVAL discards the op.
        repeat (6) tick();
        bus.out_ready = 1'b0;
        rand_ops();
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        nReset       = 1'b0;
        tick();
        nReset = 1'b1;
        seen   = 1'b0;
        repeat (6) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        check("rst_mid_eval_no_out", 64'(seen), 64'd0);
        check("rst_mid_eval_in_ready", 64'(bus.in_ready), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
